// File: rtl/frotaegis_pkg.sv
// Shared constants, FSM encoding and frame sizing helper for the Frotaegis frame-to-AXIS path.
package frotaegis_pkg;

  localparam int AXIS_WIDTH = 32;
  localparam logic [3:0] AXIS_KEEP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic int words_per_frame(input int data_size, input int length);
    int spw;
    spw = AXIS_WIDTH / data_size;
    return (length + spw - 1) / spw;
  endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Synchronous word FIFO with a registered output stage; count includes the word held at the output.
module axis_word_fifo #(
  parameter int DEPTH = 16,
  parameter int ADD   = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [ADD:0]     count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADD-1:0]   wr_ptr, rd_ptr;
  logic [ADD:0]     mem_cnt;
  logic             pop, load, from_mem, bypass, to_mem;

  always_comb begin
    pop      = rd_valid & rd_en;
    load     = !rd_valid | pop;
    from_mem = load & (mem_cnt != '0);
    // An empty backing store lets a new word go straight to the output register.
    bypass   = load & (mem_cnt == '0) & wr_en;
    to_mem   = wr_en & !bypass;
  end

  always_ff @(posedge clk) begin
    if (to_mem) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (to_mem) wr_ptr <= wr_ptr + 1'b1;
      if (from_mem) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (load) begin
        rd_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + {{ADD{1'b0}}, to_mem} - {{ADD{1'b0}}, from_mem};
      count   <= count + {{ADD{1'b0}}, wr_en} - {{ADD{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) assert (count < (ADD + 1)'(DEPTH));
  end

endmodule

// File: rtl/frame_axis_packer.sv
// Packs Frotaegis frame samples into 32-bit AXI-Stream words, admitting or dropping whole frames.
// Optional build macro FRAME_STATS_EN adds FrameCnt/DropCnt frame statistics outputs.
module frame_axis_packer
  import frotaegis_pkg::*;
#(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_ADD    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic                   FramEn,
  output logic [31:0]            m_axis_tdata,
  output logic [3:0]             m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   FrameDrop,
  output logic                   SeqErr,
  input  logic                   ClrErr
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]            FrameCnt,
  output logic [15:0]            DropCnt
`endif
);

  localparam int SPW   = AXIS_WIDTH / DATA_SIZE;
  localparam int WORDS = words_per_frame(DATA_SIZE, LENGTH);

  state_t                  state;
  logic [LENGTH_SIZE-1:0]  exp_idx;
  logic [AXIS_WIDTH-1:0]   acc, packed_word, pad_word, word_p0;
  logic                    vld_p0, last_p0;
  logic [FIFO_ADD:0]       fifo_count;
  logic [AXIS_WIDTH:0]     fifo_out;
  logic                    fifo_vld;
  int                      slot, exp_slot;
  logic                    admit, is_last, word_full;

  always_comb begin
    slot      = int'(FramAdd) % SPW;
    exp_slot  = int'(exp_idx) % SPW;
    is_last   = (FramAdd == LENGTH_SIZE'(LENGTH - 1));
    word_full = (slot == SPW - 1);
    // Slot 0 starts a fresh word, so a short final word is naturally zero-padded.
    packed_word = (slot == 0) ? '0 : acc;
    for (int j = 0; j < SPW; j++) begin
      if (j == slot) packed_word[j*DATA_SIZE +: DATA_SIZE] = FramData;
    end
    pad_word = (exp_slot == 0) ? '0 : acc;
    // The word registered in vld_p0 is not yet counted by the FIFO.
    admit = (int'(fifo_count) + int'(vld_p0) + WORDS) <= FIFO_DEPTH;
  end

  // Stage p0: sample capture, FSM and word hand-off to the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      exp_idx   <= '0;
      acc       <= '0;
      word_p0   <= '0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      FrameDrop <= 1'b0;
      SeqErr    <= 1'b0;
    end else begin
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      FrameDrop <= 1'b0;
      if (ClrErr) SeqErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (FramEn) begin
            if (FramAdd == '0) begin
              if (admit) begin
                acc     <= packed_word;
                exp_idx <= LENGTH_SIZE'(1);
                if (word_full || is_last) begin
                  word_p0 <= packed_word;
                  vld_p0  <= 1'b1;
                  last_p0 <= is_last;
                end
                state <= is_last ? ST_IDLE : ST_PACK;
              end else begin
                FrameDrop <= 1'b1;
                state     <= is_last ? ST_IDLE : ST_DROP;
              end
            end else begin
              SeqErr <= 1'b1;
            end
          end
        end
        ST_PACK: begin
          if (FramEn) begin
            if (FramAdd != exp_idx) begin
              SeqErr  <= 1'b1;
              word_p0 <= pad_word;
              vld_p0  <= 1'b1;
              last_p0 <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              acc     <= packed_word;
              exp_idx <= exp_idx + 1'b1;
              if (word_full || is_last) begin
                word_p0 <= packed_word;
                vld_p0  <= 1'b1;
                last_p0 <= is_last;
              end
              if (is_last) state <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (FramEn && is_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: word FIFO with registered AXIS output
  axis_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ADD   (FIFO_ADD),
    .WIDTH (AXIS_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_p0),
    .wr_data  ({last_p0, word_p0}),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_out),
    .rd_valid (fifo_vld),
    .count    (fifo_count)
  );

  assign m_axis_tdata  = fifo_out[AXIS_WIDTH-1:0];
  assign m_axis_tlast  = fifo_out[AXIS_WIDTH];
  assign m_axis_tvalid = fifo_vld;
  assign m_axis_tkeep  = AXIS_KEEP;

`ifdef FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || ClrErr) begin
      FrameCnt <= '0;
      DropCnt  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) FrameCnt <= FrameCnt + 16'd1;
      if (FrameDrop) DropCnt <= DropCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_axis_packer.sv
// Scoreboard bench for frame_axis_packer: expected words are queued as frames are driven and popped on AXIS handshakes.
module tb_frame_axis_packer;

  localparam int LEN = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  FramData = '0;
  logic [5:0]  FramAdd = '0;
  logic        FramEn = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        FrameDrop;
  logic        SeqErr;
  logic        ClrErr = 1'b0;
`ifdef FRAME_STATS_EN
  logic [15:0] FrameCnt;
  logic [15:0] DropCnt;
`endif

  frame_axis_packer dut (
    .clk           (clk),
    .rst           (rst),
    .FramData      (FramData),
    .FramAdd       (FramAdd),
    .FramEn        (FramEn),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .FrameDrop     (FrameDrop),
    .SeqErr        (SeqErr),
    .ClrErr        (ClrErr)
`ifdef FRAME_STATS_EN
    ,
    .FrameCnt      (FrameCnt),
    .DropCnt       (DropCnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [32:0] sb[$];
  int          cyc = 0;
  int          rx_words = 0;
  int          rx_lasts = 0;
  int          drop_hi = 0;
  int          first_vld_cyc = -1;
  int          s7_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;
  logic [32:0] exp_w;
  bit          tog_done = 0;
  int          b_words, b_lasts, b_drop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev_out);
      if (FrameDrop) drop_hi++;
      if (first_vld_cyc < 0 && m_axis_tvalid) first_vld_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        rx_words++;
        if (m_axis_tlast) rx_lasts++;
        if (sb.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          exp_w = sb.pop_front();
          chk("tdata", m_axis_tdata, exp_w[31:0]);
          chk("tlast", m_axis_tlast, exp_w[32]);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    end
  end

  // mode 0: ramp data, mode 1: random data; skip_at>=0 jumps FramAdd from skip_at to skip_at+2
  task automatic drive_frame(input int mode, input bit admit, input int skip_at, input int n_samp);
    logic [31:0] acc;
    logic [3:0]  d;
    bit          stop;
    acc  = '0;
    stop = 0;
    for (int i = 0; i < n_samp; i++) begin
      if (skip_at >= 0 && i == skip_at + 1) continue;
      d = (mode == 0) ? 4'(i) : 4'($urandom);
      @(posedge clk); #1;
      FramEn = 1'b1; FramAdd = 6'(i); FramData = d;
      if (i == 7 && s7_cyc < 0) s7_cyc = cyc;
      if (admit && !stop) begin
        if (skip_at >= 0 && i > skip_at) begin
          stop = 1;
          sb.push_back({1'b1, acc});
        end else begin
          acc[4*(i%8) +: 4] = d;
          if (i % 8 == 7) begin
            sb.push_back({(i == LEN - 1), acc});
            acc = '0;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      FramEn = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_left", sb.size(), 0);
    chk("tvalid_after_drain", m_axis_tvalid, 0);
  endtask

  task automatic clr_err();
    @(posedge clk); #1 ClrErr = 1'b1;
    @(posedge clk); #1 ClrErr = 1'b0;
    @(negedge clk);
  endtask

  task automatic snap();
    b_words = rx_words; b_lasts = rx_lasts; b_drop = drop_hi;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_drop", FrameDrop, 0);
    chk("rst_seqerr", SeqErr, 0);
    chk("tkeep", m_axis_tkeep, 4'hF);

    // 1: ramp frame, tready high
    m_axis_tready = 1'b1;
    snap();
    drive_frame(0, 1, -1, LEN);
    idle(1);
    drain();
    chk("t1_words", rx_words - b_words, 8);
    chk("t1_lasts", rx_lasts - b_lasts, 1);
    chk("t1_drop", drop_hi - b_drop, 0);
    chk("t1_latency", first_vld_cyc - s7_cyc, 2);
    chk("t1_seqerr", SeqErr, 0);

    // 2: tready toggling
    snap();
    tog_done = 0;
    fork
      begin
        drive_frame(0, 1, -1, LEN);
        idle(1);
        tog_done = 1;
      end
      begin
        for (int n = 0; n < 400 && !(tog_done && sb.size() == 0); n++) begin
          @(posedge clk); #1 m_axis_tready = ~m_axis_tready;
        end
      end
    join
    m_axis_tready = 1'b1;
    drain();
    chk("t2_words", rx_words - b_words, 8);
    chk("t2_lasts", rx_lasts - b_lasts, 1);

    // 3: FIFO fills with two frames, third is dropped
`ifdef FRAME_STATS_EN
    clr_err();
    chk("stats_clr_frame", FrameCnt, 0);
    chk("stats_clr_drop", DropCnt, 0);
`endif
    m_axis_tready = 1'b0;
    snap();
    drive_frame(0, 1, -1, LEN);
    drive_frame(1, 1, -1, LEN);
    drive_frame(0, 0, -1, LEN);
    idle(2);
    @(negedge clk);
    chk("t3_drop_pulses", drop_hi - b_drop, 1);
    chk("t3_stalled_valid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    drain();
    chk("t3_words", rx_words - b_words, 16);
    chk("t3_lasts", rx_lasts - b_lasts, 2);
`ifdef FRAME_STATS_EN
    chk("stats_frames", FrameCnt, 2);
    chk("stats_drops", DropCnt, 1);
    clr_err();
    chk("stats_clr2_frame", FrameCnt, 0);
    chk("stats_clr2_drop", DropCnt, 0);
`endif

    // 4: index skip 10->12, then a normal frame
    snap();
    drive_frame(0, 1, 10, LEN);
    drive_frame(1, 1, -1, LEN);
    idle(1);
    drain();
    chk("t4_seqerr", SeqErr, 1);
    chk("t4_words", rx_words - b_words, 10);
    chk("t4_lasts", rx_lasts - b_lasts, 2);
    clr_err();
    chk("t4_seqerr_clr", SeqErr, 0);
    @(posedge clk); #1;
    FramEn = 1'b1; FramAdd = 6'd5; ClrErr = 1'b1;
    @(posedge clk); #1;
    FramEn = 1'b0; ClrErr = 1'b0;
    @(negedge clk);
    chk("t4_set_beats_clr", SeqErr, 1);
    clr_err();
    chk("t4_seqerr_clr2", SeqErr, 0);

    // 5: reset mid-frame with words waiting in the FIFO
    m_axis_tready = 1'b0;
    drive_frame(0, 0, -1, 30);
    @(negedge clk);
    chk("t5_words_waiting", m_axis_tvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1; FramAdd = 6'd30; FramEn = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; FramEn = 1'b0;
    @(negedge clk);
    chk("t5_tvalid_after_rst", m_axis_tvalid, 0);
    snap();
    m_axis_tready = 1'b1;
    idle(20);
    @(negedge clk);
    chk("t5_fifo_empty", rx_words - b_words, 0);
    drive_frame(1, 1, -1, LEN);
    idle(1);
    drain();
    chk("t5_words", rx_words - b_words, 8);
    chk("t5_lasts", rx_lasts - b_lasts, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
